// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier issue controller: state encoding,
// datapath widths and the default watchdog limit.
package mult_pkg;

  localparam int OP_W               = 32;
  localparam int PROD_W             = 64;
  localparam int DEF_TIMEOUT_CYCLES = 40;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  function automatic logic is_zero_op(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b);
    return (a == {OP_W{1'b0}}) || (b == {OP_W{1'b0}});
  endfunction

endpackage

// File: rtl/mult_watchdog.sv
// Cycle watchdog for the multiplier: counts enabled cycles since the last clear
// and flags the cycle in which the count equals TIMEOUT_CYCLES-1.
module mult_watchdog #(
  parameter int TIMEOUT_CYCLES = 40
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;

  assign cnt_nxt_s = cnt_r + CNT_W'(1);

  // Count register with a registered terminal flag that tracks the count value.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r    <= {CNT_W{1'b0}};
      terminal <= 1'b0;
    end else if (clear) begin
      cnt_r    <= {CNT_W{1'b0}};
      terminal <= 1'b0;
    end else if (enable && !terminal) begin
      cnt_r    <= cnt_nxt_s;
      terminal <= (cnt_nxt_s == CNT_W'(TIMEOUT_CYCLES - 1));
    end else begin
      cnt_r    <= cnt_r;
      terminal <= terminal;
    end
  end

endmodule

// File: rtl/mult_issue_ctrl.sv
// Request/response sequencer for the iterative 32x32 signed multiplier.
// Optional build macro MULT_ZERO_BYPASS_EN answers zero-operand requests without launching the multiplier.
module mult_issue_ctrl
  import mult_pkg::*;
#(
  parameter int TAG_W          = 4,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [OP_W-1:0]   req_op1,
  input  logic [OP_W-1:0]   req_op2,
  input  logic [TAG_W-1:0]  req_tag,
  output logic              mult_begin,
  output logic [OP_W-1:0]   mult_op1,
  output logic [OP_W-1:0]   mult_op2,
  input  logic [PROD_W-1:0] mult_product,
  input  logic              mult_end,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [OP_W-1:0]   rsp_hi,
  output logic [OP_W-1:0]   rsp_lo,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic              rsp_timeout,
  output logic [OP_W-1:0]   hi_q,
  output logic [OP_W-1:0]   lo_q,
  output logic              busy
);

  state_e          state_r;
  logic [OP_W-1:0] op1_r;
  logic [OP_W-1:0] op2_r;
  logic            wd_clear_s;
  logic            wd_enable_s;
  logic            wd_term_s;

  // Operands stay in the latch registers for the whole BUSY phase.
  assign mult_op1    = op1_r;
  assign mult_op2    = op2_r;
  assign wd_clear_s  = (state_r == IDLE) && req_valid && req_ready;
  assign wd_enable_s = (state_r == BUSY);

  mult_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (wd_clear_s),
    .enable  (wd_enable_s),
    .terminal(wd_term_s)
  );

  // Controller FSM with all handshake and response outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      req_ready   <= 1'b1;
      mult_begin  <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_timeout <= 1'b0;
      rsp_hi      <= {OP_W{1'b0}};
      rsp_lo      <= {OP_W{1'b0}};
      rsp_tag     <= {TAG_W{1'b0}};
      hi_q        <= {OP_W{1'b0}};
      lo_q        <= {OP_W{1'b0}};
      op1_r       <= {OP_W{1'b0}};
      op2_r       <= {OP_W{1'b0}};
      busy        <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_valid && req_ready) begin
            op1_r     <= req_op1;
            op2_r     <= req_op2;
            rsp_tag   <= req_tag;
            req_ready <= 1'b0;
            busy      <= 1'b1;
`ifdef MULT_ZERO_BYPASS_EN
            if (is_zero_op(req_op1, req_op2)) begin
              rsp_hi      <= {OP_W{1'b0}};
              rsp_lo      <= {OP_W{1'b0}};
              rsp_timeout <= 1'b0;
              rsp_valid   <= 1'b1;
              state_r     <= RESP;
            end else begin
              mult_begin <= 1'b1;
              state_r    <= BUSY;
            end
`else
            mult_begin <= 1'b1;
            state_r    <= BUSY;
`endif
          end
        end
        BUSY: begin
          // The product is final in the very cycle mult_end is seen.
          if (mult_end) begin
            rsp_hi      <= mult_product[PROD_W-1:OP_W];
            rsp_lo      <= mult_product[OP_W-1:0];
            rsp_timeout <= 1'b0;
            rsp_valid   <= 1'b1;
            mult_begin  <= 1'b0;
            state_r     <= RESP;
          end else if (wd_term_s) begin
            rsp_hi      <= {OP_W{1'b0}};
            rsp_lo      <= {OP_W{1'b0}};
            rsp_timeout <= 1'b1;
            rsp_valid   <= 1'b1;
            mult_begin  <= 1'b0;
            state_r     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            if (!rsp_timeout) begin
              hi_q <= rsp_hi;
              lo_q <= rsp_lo;
            end
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            state_r   <= IDLE;
          end
        end
        default: begin
          state_r    <= IDLE;
          req_ready  <= 1'b1;
          mult_begin <= 1'b0;
          rsp_valid  <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule
